// File: rtl/uriscv_axi_rd_arb.sv
// uriscv_axi_rd_arb
// Shares one AXI4 read channel (AR/R) between the instruction-fetch port (M0)
// and the data-read port (M1). Round-robin arbitration, registered AR outputs,
// a single outstanding single-beat read, and read data routed back to the
// master that owns the current transaction.
module uriscv_axi_rd_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  // M0: instruction fetch
  input  logic              m0_rd_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic              m0_accept_o,
  output logic              m0_valid_o,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_err_o,

  // M1: data read
  input  logic              m1_rd_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic              m1_accept_o,
  output logic              m1_valid_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_err_o,

  // AXI4 read address channel
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,

  // AXI4 read data channel
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,

  output logic              busy_o
);

  // Bytes per data word and the mask that clears the byte-offset bits so
  // every AR address is word aligned.
  localparam int                BYTES_W   = DATA_W / 8;
  localparam int                SIZE_LOG2 = $clog2(BYTES_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              sel_q, sel_d;          // master owning the transaction
  logic              last_grant_q, last_grant_d;

  logic              any_req;
  logic              win;
  logic [ADDR_W-1:0] win_addr;
  logic              ar_fire;
  logic              r_done;
  logic              r_is_err;

  // Single-burst, full-width, incrementing reads only.
  assign arlen   = 8'h00;
  assign arsize  = 3'(SIZE_LOG2);
  assign arburst = 2'b01;

  assign araddr  = araddr_q;
  assign arvalid = arvalid_q;

  // Read data is broadcast; only the valid strobe says who it belongs to.
  assign m0_data_o = rdata;
  assign m1_data_o = rdata;

  assign ar_fire  = (state_q == ST_ADDR) && arvalid_q && arready;
  assign r_done   = (state_q == ST_DATA) && rvalid && rlast;
  // SLVERR (2'b10) and DECERR (2'b11) are errors; OKAY/EXOKAY are not.
  assign r_is_err = (rresp == 2'b10) || (rresp == 2'b11);

  // Round-robin pick: a lone requester wins, a tie goes to the master that
  // did not win last time.
  always_comb begin
    any_req = m0_rd_i | m1_rd_i;
    if (m0_rd_i && m1_rd_i) begin
      win = ~last_grant_q;
    end else begin
      win = m1_rd_i;
    end
    win_addr = (win ? m1_addr_i : m0_addr_i) & ALIGN_MASK;
  end

  // State register: FSM state, AR outputs, owner and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;   // so M0 wins the first tie
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic: arbitrate in IDLE or on the closing R beat, hold AR
  // stable until accepted, then wait for the last R beat.
  always_comb begin
    state_d      = state_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d   = ST_ADDR;
          arvalid_d = 1'b1;
          araddr_d  = win_addr;
          sel_d     = win;
        end
      end

      ST_ADDR: begin
        if (ar_fire) begin
          state_d      = ST_DATA;
          arvalid_d    = 1'b0;
          last_grant_d = sel_q;
        end
      end

      ST_DATA: begin
        if (r_done) begin
          // Back-to-back: a pending request goes straight to ADDR so the
          // next arvalid appears the cycle after the last beat.
          if (any_req) begin
            state_d   = ST_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = win_addr;
            sel_d     = win;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // Output logic: accept on the AR handshake, valid/err on the last R beat,
  // both steered by the owner; rready only while waiting for data.
  always_comb begin
    m0_accept_o = 1'b0;
    m1_accept_o = 1'b0;
    m0_valid_o  = 1'b0;
    m1_valid_o  = 1'b0;
    m0_err_o    = 1'b0;
    m1_err_o    = 1'b0;
    rready      = (state_q == ST_DATA);
    busy_o      = (state_q != ST_IDLE);

    if (ar_fire) begin
      if (sel_q) m1_accept_o = 1'b1;
      else       m0_accept_o = 1'b1;
    end

    // Non-last beats are consumed by rready but produce no strobe.
    if (r_done) begin
      if (sel_q) begin
        m1_valid_o = 1'b1;
        m1_err_o   = r_is_err;
      end else begin
        m0_valid_o = 1'b1;
        m0_err_o   = r_is_err;
      end
    end
  end

endmodule

// File: tb/tb_uriscv_axi_rd_arb.sv
// tb_uriscv_axi_rd_arb
// Directed bench for the two-master AXI read arbiter. Expected AR grants and
// R completions are queued when stimulus is set up and popped when the DUT
// performs the corresponding handshake.
module tb_uriscv_axi_rd_arb;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              m0_rd_i, m1_rd_i;
  logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
  logic              m0_accept_o, m1_accept_o;
  logic              m0_valid_o, m1_valid_o;
  logic [DATA_W-1:0] m0_data_o, m1_data_o;
  logic              m0_err_o, m1_err_o;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid, arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;
  logic              busy_o;

  uriscv_axi_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_rd_i(m0_rd_i), .m0_addr_i(m0_addr_i), .m0_accept_o(m0_accept_o),
    .m0_valid_o(m0_valid_o), .m0_data_o(m0_data_o), .m0_err_o(m0_err_o),
    .m1_rd_i(m1_rd_i), .m1_addr_i(m1_addr_i), .m1_accept_o(m1_accept_o),
    .m1_valid_o(m1_valid_o), .m1_data_o(m1_data_o), .m1_err_o(m1_err_o),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        m;
    logic [31:0] addr;
  } ar_exp_t;

  typedef struct {
    logic        m;
    logic [31:0] data;
    logic        err;
  } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  logic    cur_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for arvalid, hold arready low for low_cycles cycles, then accept.
  // Leaves the bench at the first negedge of the DATA phase.
  task automatic do_ar(input int low_cycles, input logic drop);
    ar_exp_t e;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (arvalid !== 1'b1 && n < 20);
    chk("ar_q_nonempty", 64'(ar_q.size() != 0), 64'd1);
    if (ar_q.size() == 0) return;
    e = ar_q.pop_front();
    chk("ar_latency", 64'(n), 64'd1);
    for (int k = 0; k < low_cycles; k++) begin
      chk("ar_hold_valid", 64'(arvalid), 64'd1);
      chk("ar_hold_addr", 64'(araddr), 64'(e.addr));
      chk("ar_hold_noacc", 64'({m1_accept_o, m0_accept_o}), 64'd0);
      @(negedge clk);
    end
    arready = 1'b1;
    #1;
    chk("ar_addr", 64'(araddr), 64'(e.addr));
    chk("m0_accept", 64'(m0_accept_o), 64'(e.m == 1'b0));
    chk("m1_accept", 64'(m1_accept_o), 64'(e.m == 1'b1));
    cur_m = e.m;
    @(negedge clk);
    arready = 1'b0;
    if (drop) begin
      if (e.m) m1_rd_i = 1'b0;
      else     m0_rd_i = 1'b0;
    end
    chk("data_arvalid_low", 64'(arvalid), 64'd0);
    chk("data_rready", 64'(rready), 64'd1);
    chk("data_busy", 64'(busy_o), 64'd1);
  endtask

  // Drive extra non-last beats then the last beat; check routing on the last.
  task automatic do_r(input int extra_beats, input logic [31:0] data, input logic [1:0] resp);
    r_exp_t e;
    r_q.push_back('{m: cur_m, data: data, err: resp[1]});
    for (int k = 0; k < extra_beats; k++) begin
      rvalid = 1'b1; rlast = 1'b0; rdata = ~data; rresp = resp;
      #1;
      chk("beat_novalid", 64'({m1_valid_o, m0_valid_o}), 64'd0);
      chk("beat_rready", 64'(rready), 64'd1);
      @(negedge clk);
    end
    rvalid = 1'b1; rlast = 1'b1; rdata = data; rresp = resp;
    #1;
    e = r_q.pop_front();
    chk("m0_valid", 64'(m0_valid_o), 64'(e.m == 1'b0));
    chk("m1_valid", 64'(m1_valid_o), 64'(e.m == 1'b1));
    chk("r_data", 64'(e.m ? m1_data_o : m0_data_o), 64'(e.data));
    chk("r_err", 64'(e.m ? m1_err_o : m0_err_o), 64'(e.err));
    chk("other_err", 64'(e.m ? m0_err_o : m1_err_o), 64'd0);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_rd_i = 1'b0; m1_rd_i = 1'b0; m0_addr_i = '0; m1_addr_i = '0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    cur_m = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_strobes", 64'({m0_accept_o, m1_accept_o, m0_valid_o, m1_valid_o, m0_err_o, m1_err_o}), 64'd0);
    chk("ar_const", 64'({arlen, arsize, arburst}), 64'({8'h00, 3'h2, 2'b01}));
    rst_n = 1'b1;
    @(negedge clk);

    // T2: single M0 read, unaligned address
    m0_rd_i = 1'b1; m0_addr_i = 32'h2000_0006;
    ar_q.push_back('{m: 1'b0, addr: 32'h2000_0004});
    do_ar(0, 1'b1);
    do_r(0, 32'hDEAD_BEEF, 2'b00);
    chk("t2_idle", 64'(busy_o), 64'd0);

    // T1: reset asserted during ADDR, R beat during reset ignored
    m1_rd_i = 1'b1; m1_addr_i = 32'h4000_0000;
    @(posedge clk);
    #1;
    chk("t1_addr_phase", 64'(arvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_arvalid", 64'(arvalid), 64'd0);
    chk("t1_rready", 64'(rready), 64'd0);
    chk("t1_busy", 64'(busy_o), 64'd0);
    rvalid = 1'b1; rlast = 1'b1;
    #1;
    chk("t1_r_ignored", 64'({rready, m1_valid_o, m0_valid_o}), 64'd0);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0; m1_rd_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T3: both held continuously, grants alternate starting with M0
    m0_rd_i = 1'b1; m0_addr_i = 32'h0000_0103;
    m1_rd_i = 1'b1; m1_addr_i = 32'h0000_0207;
    for (int i = 0; i < 4; i++) begin
      ar_q.push_back('{m: i[0], addr: (i[0] ? 32'h0000_0204 : 32'h0000_0100)});
    end
    for (int i = 0; i < 4; i++) begin
      do_ar(0, 1'b0);
      if (i == 3) begin
        m0_rd_i = 1'b0; m1_rd_i = 1'b0;
      end
      do_r(0, 32'hA5A5_0000 + 32'(i), 2'b00);
    end
    chk("t3_idle", 64'(busy_o), 64'd0);

    // T4: arready held low 5 cycles; M1 arrives while M0 owns the channel
    m0_rd_i = 1'b1; m0_addr_i = 32'h1000_0013;
    ar_q.push_back('{m: 1'b0, addr: 32'h1000_0010});
    @(posedge clk);
    #1;
    m1_rd_i = 1'b1; m1_addr_i = 32'h3000_000B;
    do_ar(5, 1'b1);
    // T6: M1 pending at the last beat -> AR for M1 the very next cycle
    ar_q.push_back('{m: 1'b1, addr: 32'h3000_0008});
    do_r(0, 32'h1234_5678, 2'b00);
    do_ar(0, 1'b1);
    // T5: M1 read with SLVERR, preceded by two non-last beats
    do_r(2, 32'hCAFE_F00D, 2'b10);

    // R beat while idle is not consumed
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0BAD_0BAD;
    #1;
    chk("idle_r_ignored", 64'({rready, busy_o, m1_valid_o, m0_valid_o}), 64'd0);
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    chk("end_idle", 64'({busy_o, arvalid}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
